// File: rtl/debug_jtag_scan_master.sv
// debug_jtag_scan_master: virtual-JTAG scan initiator for the debug slave (optional DEBUG_SCAN_IR_SKIP_EN skips redundant IR updates)
module debug_jtag_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);
  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI} state_t;
  state_t              r_st;
  logic [CW-1:0]       r_cnt;
  logic [BW-1:0]       r_bit;
  logic [DR_WIDTH-1:0] r_sh;
  logic [DR_WIDTH-1:0] r_rsp;
  logic [IR_WIDTH-1:0] r_ir;
  logic [IR_WIDTH-1:0] r_rsp_ir;
  logic                r_tck, r_tdi, r_uir, r_cdr, r_sdr, r_udr, r_rti, r_rsp_valid, r_ready;
  logic                w_acc, w_half, w_skip;
`ifdef DEBUG_SCAN_IR_SKIP_EN
  logic [IR_WIDTH-1:0] r_last_ir;
  logic                r_ir_valid;
  assign w_skip = r_ir_valid && (cmd_ir == r_last_ir);
`else
  assign w_skip = 1'b0;
`endif
  assign w_acc  = cmd_valid && r_ready;
  assign w_half = (r_cnt == CW'(TCK_DIV - 1));
  assign cmd_ready      = r_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp;
  assign rsp_ir_out     = r_rsp_ir;
  assign tck            = r_tck;
  assign tdi            = r_tdi;
  assign ir_in          = r_ir;
  assign vs_uir         = r_uir;
  assign vs_cdr         = r_cdr;
  assign vs_sdr         = r_sdr;
  assign vs_udr         = r_udr;
  assign jtag_state_rti = r_rti;
  // Scan sequencer: TCK generation, strobe sequencing, shifting and response handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st        <= IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_sh        <= '0;
      r_rsp       <= '0;
      r_ir        <= '0;
      r_rsp_ir    <= '0;
      r_tck       <= 1'b0;
      r_tdi       <= 1'b0;
      r_uir       <= 1'b0;
      r_cdr       <= 1'b0;
      r_sdr       <= 1'b0;
      r_udr       <= 1'b0;
      r_rti       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_ready     <= 1'b1;
`ifdef DEBUG_SCAN_IR_SKIP_EN
      r_last_ir   <= '0;
      r_ir_valid  <= 1'b0;
`endif
    end else if (r_st == IDLE) begin
      if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_ready     <= 1'b1;
      end
      if (w_acc) begin
        r_ready <= 1'b0;
        r_ir    <= cmd_ir;
        r_sh    <= cmd_data;
        r_cnt   <= '0;
        r_tck   <= 1'b0;
        r_st    <= w_skip ? CDR : UIR;
        r_uir   <= !w_skip;
        r_cdr   <= w_skip;
`ifdef DEBUG_SCAN_IR_SKIP_EN
        if (!w_skip) begin
          r_ir_valid <= 1'b1;
          r_last_ir  <= cmd_ir;
        end
`endif
      end
    end else begin
      r_cnt <= w_half ? '0 : r_cnt + 1'b1;
      if (w_half) r_tck <= !r_tck;
      if (w_half && !r_tck && r_st == SDR) r_rsp <= {tdo, r_rsp[DR_WIDTH-1:1]};
      if (w_half && !r_tck && r_st == UDR) r_rsp_ir <= ir_out;
      if (w_half && r_tck) begin
        r_uir <= 1'b0;
        r_cdr <= 1'b0;
        r_sdr <= 1'b0;
        r_udr <= 1'b0;
        r_rti <= 1'b0;
        r_tdi <= 1'b0;
        case (r_st)
          UIR: begin
            r_st  <= CDR;
            r_cdr <= 1'b1;
          end
          CDR: begin
            r_st  <= SDR;
            r_sdr <= 1'b1;
            r_tdi <= r_sh[0];
            r_sh  <= r_sh >> 1;
            r_bit <= '0;
          end
          SDR: begin
            if (r_bit == BW'(DR_WIDTH - 1)) begin
              r_st  <= UDR;
              r_udr <= 1'b1;
            end else begin
              r_sdr <= 1'b1;
              r_tdi <= r_sh[0];
              r_sh  <= r_sh >> 1;
              r_bit <= r_bit + 1'b1;
            end
          end
          UDR: begin
            r_st  <= RTI;
            r_rti <= 1'b1;
          end
          default: begin
            r_st        <= IDLE;
            r_rsp_valid <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_debug_jtag_scan_master.sv
// tb_debug_jtag_scan_master: randomized scans against behavioural virtual-JTAG slave models
module tb_debug_jtag_scan_master;
  logic clk = 1'b0, reset;
  always #5 clk = ~clk;
  logic cmd_valid, cmd_ready, rsp_valid, rsp_ready, tck, tdi, tdo;
  logic vs_uir, vs_cdr, vs_sdr, vs_udr, rti;
  logic [1:0] cmd_ir, rsp_ir_out, ir_in, ir_out;
  logic [37:0] cmd_data, rsp_data;
  logic b_cmd_valid, b_cmd_ready, b_rsp_valid, b_tck, b_tdi;
  logic b_uir, b_cdr, b_sdr, b_udr, b_rti;
  logic [1:0] b_rsp_ir_out, b_ir_in;
  logic [37:0] b_cmd_data, b_rsp_data;
  logic [1:0] b_cmd_ir;
  logic b_lb;
  int n_cmp = 0, n_bad = 0;
  int mode;
  logic [37:0] cap, sr;
  logic lb, m_valid;
  logic [1:0] m_last;
  debug_jtag_scan_master dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_ir_out(rsp_ir_out), .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .jtag_state_rti(rti)
  );
  debug_jtag_scan_master #(.TCK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_ir(b_cmd_ir),
    .cmd_data(b_cmd_data), .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_data(b_rsp_data),
    .rsp_ir_out(b_rsp_ir_out), .tck(b_tck), .tdi(b_tdi), .tdo(b_lb), .ir_in(b_ir_in), .ir_out(2'b01),
    .vs_uir(b_uir), .vs_cdr(b_cdr), .vs_sdr(b_sdr), .vs_udr(b_udr), .jtag_state_rti(b_rti)
  );
  // slave models: mode 0 is a one-bit loopback, mode 1 is a capture/shift register
  always @(posedge tck) begin
    if (vs_cdr) begin
      lb <= 1'b0;
      sr <= cap;
    end else if (vs_sdr) begin
      lb <= tdi;
      sr <= {tdi, sr[37:1]};
    end
  end
  assign tdo = mode ? sr[0] : lb;
  always @(posedge b_tck) begin
    if (b_cdr) b_lb <= 1'b0;
    else if (b_sdr) b_lb <= b_tdi;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic scan(input logic [1:0] ir, input logic [37:0] d, input int hold, input logic [1:0] io);
    logic [37:0] exp;
    logic skip;
    int n, lat, cu, cc, cs, cd, cr;
    skip = 1'b0;
`ifdef DEBUG_SCAN_IR_SKIP_EN
    skip = m_valid && ir == m_last;
`endif
    if (!skip) begin
      m_valid = 1'b1;
      m_last = ir;
    end
    exp = mode ? cap : {d[36:0], 1'b0};
    @(negedge clk);
    ir_out = io;
    cmd_ir = ir;
    cmd_data = d;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("accept", n < 300, 1);
    lat = -1; cu = 0; cc = 0; cs = 0; cd = 0; cr = 0;
    for (int k = 1; k < 1000; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_data = ~d;
        cmd_ir = ~ir;
        cmd_valid = hold > 0;
        check("ir_in", ir_in, ir);
      end
      cu += vs_uir; cc += vs_cdr; cs += vs_sdr; cd += vs_udr; cr += rti;
      if (rsp_valid) begin
        lat = k - 1;
        break;
      end
    end
    check("latency", lat, skip ? 164 : 168);
    check("uir_cycles", cu, skip ? 0 : 4);
    check("cdr_cycles", cc, 4);
    check("sdr_cycles", cs, 152);
    check("udr_cycles", cd, 4);
    check("rti_cycles", cr, 4);
    check("rsp_data", rsp_data, exp);
    check("rsp_ir_out", rsp_ir_out, io);
    check("ir_in_hold", ir_in, ir);
    check("busy_ready", cmd_ready, 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      cmd_data = {$urandom, $urandom};
      check("bp_ready", cmd_ready, 0);
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, exp);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("consumed", rsp_valid, 0);
    check("ready_back", cmd_ready, 1);
    check("idle_tck", tck, 0);
  endtask
  task automatic abort_scan(input logic [1:0] ir, input logic [37:0] d);
    int n, cs, seen;
    @(negedge clk);
    cmd_ir = ir;
    cmd_data = d;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    cs = 0;
    for (int k = 1; k < 1000 && cs < 41; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cs += vs_sdr;
    end
    check("sdr_reach", cs, 41);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_valid = 1'b0;
    check("abort_tck", tck, 0);
    check("abort_sdr", vs_sdr, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_ir", ir_in, 0);
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      seen += rsp_valid;
    end
    check("abort_no_rsp", seen, 0);
  endtask
  initial begin
    logic [63:0] t;
    logic [37:0] e;
    int lat, s, z, nt;
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_ir = 2'b00; cmd_data = '0; ir_out = 2'b00;
    b_cmd_valid = 1'b0; b_cmd_ir = 2'b00; b_cmd_data = '0;
    mode = 0; cap = '0; m_valid = 1'b0; m_last = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_tck", tck, 0);
    check("rst_tdi", tdi, 0);
    check("rst_strobes", {vs_uir, vs_cdr, vs_sdr, vs_udr, rti}, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_ir_in", ir_in, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_ir", rsp_ir_out, 0);
    check("rst_ready", cmd_ready, 1);
    reset = 1'b0;
    scan(2'b01, 38'h2A_5555_AAAA, 0, 2'b00);
    mode = 1;
    cap = 38'h3F_0000_0001;
    scan(2'b10, 38'h15_1234_5678, 0, 2'b10);
    t = {$urandom, $urandom};
    scan(2'($urandom), t[37:0], 50, 2'($urandom));
    abort_scan(2'b01, 38'h0F_F0F0_F0F0);
    mode = 0;
    scan(2'b01, 38'h01_8000_0003, 0, 2'b11);
    scan(2'b11, 38'h33_CCCC_3333, 0, 2'b01);
    scan(2'b11, 38'h0C_3333_CCCC, 1, 2'b10);
    scan(2'b00, 38'h20_0000_0001, 0, 2'b00);
    for (int i = 0; i < 10; i++) begin
      mode = $urandom % 2;
      t = {$urandom, $urandom};
      cap = t[37:0];
      t = {$urandom, $urandom};
      scan(2'($urandom_range(0, 3)), t[37:0], $urandom % 4, 2'($urandom));
    end
    @(negedge clk);
    b_cmd_ir = 2'b10;
    b_cmd_data = '1;
    b_cmd_valid = 1'b1;
    check("b_ready", b_cmd_ready, 1);
    lat = -1; s = 0; z = 0; nt = 0;
    for (int k = 1; k < 500; k++) begin
      @(negedge clk);
      b_cmd_valid = 1'b0;
      if (b_sdr) begin
        s++;
        z += !b_tdi;
      end
      nt += (b_tck != 1'((k - 1) & 1));
      if (b_rsp_valid) begin
        lat = k - 1;
        break;
      end
    end
    e = '1;
    e = {e[36:0], 1'b0};
    check("b_latency", lat, 84);
    check("b_sdr_cycles", s, 76);
    check("b_tdi_ones", z, 0);
    check("b_tck_period", nt, 0);
    check("b_rsp_data", b_rsp_data, e);
    check("b_rsp_ir", b_rsp_ir_out, 2'b01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/debug_jtag_scan_master.md
Name: debug_jtag_scan_master

Overview:
- Host-side initiator for the Nios II debug slave's virtual-JTAG interface.
- Drives the virtual TAP strobes (tck, tdi, ir_in, uir/cdr/sdr/udr, rti) that the debug slave's TCK-domain logic consumes, and captures tdo.
- Turns one command (2-bit IR plus 38-bit DR word) into a full IR-update / DR-capture / DR-shift / DR-update / run-test-idle sequence and returns the shifted-out word.
- Used by on-chip debug bring-up logic and as the stimulus driver in debug-slave simulation benches.

Parameters:
- DR_WIDTH, 38: DR scan length in bits; matches the debug slave's sr/jdo width.
- IR_WIDTH, 2: virtual IR width.
- TCK_DIV, 2: TCK half-period in clk cycles; legal range is 1 or more.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on a clk edge.
- cmd_ir  in  IR_WIDTH  IR value for the scan.
- cmd_data  in  DR_WIDTH  DR word to shift in, LSB first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_data  out  DR_WIDTH  tdo bits captured during the shift; bit i is the i-th bit out.
- rsp_ir_out  out  IR_WIDTH  ir_out value sampled at UDR.
- tck  out  1  generated TCK.
- tdi  out  1  serial data to the slave.
- tdo  in  1  serial data from the slave.
- ir_in  out  IR_WIDTH  virtual IR value.
- ir_out  in  IR_WIDTH  slave status IR.
- vs_uir  out  1  virtual update-IR strobe.
- vs_cdr  out  1  virtual capture-DR strobe.
- vs_sdr  out  1  virtual shift-DR strobe.
- vs_udr  out  1  virtual update-DR strobe.
- jtag_state_rti  out  1  run-test-idle indication.

Behaviour:
- Reset values:
  - Low: tck, tdi, all vs_* strobes, rti, rsp_valid.
  - Zero: ir_in, rsp_data, rsp_ir_out.
  - cmd_ready is 1. State is IDLE.
- TCK period:
  - One period is 2*TCK_DIV clk cycles: a low phase of TCK_DIV cycles, then a high phase of TCK_DIV cycles.
  - tck is registered and toggles only inside a scan. In IDLE, tck stays low.
- States:
  - IDLE: cmd_ready = !rsp_valid. On accept, latch cmd_ir and cmd_data, drive ir_in = cmd_ir, then go to UIR.
  - UIR: one period with vs_uir=1.
  - CDR: one period with vs_cdr=1.
  - SDR: DR_WIDTH periods with vs_sdr=1.
  - UDR: one period with vs_udr=1. rsp_ir_out is sampled at the clk edge that raises tck.
  - RTI: one period with jtag_state_rti=1. At the end, set rsp_valid=1 and return to IDLE.
- Strobe alignment:
  - Each strobe asserts on the clk edge that starts the period's low phase.
  - It deasserts at the end of the period. There are no gaps between periods.
- Shift:
  - In SDR period i (i = 0..DR_WIDTH-1), tdi = latched cmd_data[i], set at the start of the low phase.
  - tdo is sampled into rsp_data[i] on the clk edge that drives tck high.
  - The slave shifts on tck rising, so it sees stable tdi and presents its bit on tdo before that edge.
- ir_in holds the latched cmd_ir from accept until the next accept.
- Latency: accept to rsp_valid is exactly (DR_WIDTH+4)*2*TCK_DIV clk cycles. Defaults give 168.
- Response:
  - rsp_valid holds until rsp_ready; rsp_data and rsp_ir_out stay stable meanwhile.
  - A new command cannot be accepted while rsp_valid=1.
  - On the cycle rsp_valid is consumed, cmd_ready rises the next cycle.
- cmd_valid while busy: ignored; cmd_ready=0 and the inputs are not sampled.
- Reset mid-scan: the scan aborts immediately, all outputs take reset values, and no response is produced.
- TCK_DIV=1: tck toggles every clk cycle; the sampling rules are unchanged.

Optional Feature:
- Macro: DEBUG_SCAN_IR_SKIP_EN.
- Defined:
  - The block keeps a last_ir register and an ir_valid flag, both cleared by reset.
  - On accept with ir_valid=1 and cmd_ir == last_ir, the UIR period is skipped and the scan goes straight to CDR. Latency is then (DR_WIDTH+3)*2*TCK_DIV cycles.
  - Every scan that performs UIR sets ir_valid and updates last_ir.
- Undefined: UIR is always performed and latency is fixed.

Test Plan:
- Basic scan, loopback slave model (tdo = tdi delayed by one TCK rising edge, with the captured value 0 at CDR). Send cmd_ir=2'b01, cmd_data=38'h2A_5555_AAAA.
  - Response: rsp_valid exactly 168 cycles after accept.
  - rsp_data = {cmd_data[36:0], 1'b0}.
  - vs_uir, vs_cdr, vs_udr and rti each high for 4 cycles; vs_sdr high for 152 cycles.
- Capture check. Slave model loads sr=38'h3F_0000_0001 at CDR and emits tdo=sr[0].
  - Response: rsp_data=38'h3F_0000_0001.
  - ir_out driven to 2'b10 yields rsp_ir_out=2'b10.
- Backpressure. Hold rsp_ready=0 for 50 cycles after rsp_valid, with cmd_valid=1 throughout.
  - Response: cmd_ready=0 and rsp_data stable for all 50 cycles.
  - cmd_ready=1 one cycle after the handshake, and the next command is accepted.
- Reset mid-SDR at bit 10.
  - Response: the next cycle shows tck=0, vs_sdr=0 and cmd_ready=1.
  - No rsp_valid; a following command completes normally.
- TCK_DIV=1 with cmd_data all ones.
  - Response: tck period is 2 cycles, tdi=1 for the whole of SDR, latency 84 cycles.
- With DEBUG_SCAN_IR_SKIP_EN defined, issue two back-to-back scans with cmd_ir=2'b11.
  - Response: the first scan has a vs_uir pulse and 168-cycle latency.
  - The second has no vs_uir and 164-cycle latency.
  - A third scan with cmd_ir=2'b00 pulses vs_uir again.
